hwag_ssram_slave: RTL and testbench
===================================

// Module: hwag_ssram_slave
// PURPOSE
//  Responder end of the HWAG SSRAM host bus (we/re/addr/bidirectional data) that external masters use to load config and read back.
//  Holds the RW register bank (filter, HWACR0, VR IE, ...) feeding HWAG core, a sticky W1C interrupt-flag register set by core events,
//  and read-only status words; drives the shared data bus only during reads; raises a level irq from flags & IE.
// PARAMETERS
//  ADDR_W    8    address width
//  DATA_W    16   data width
//  RW_DEPTH  68   RW registers at addr 0..RW_DEPTH-1
//  IE_ADDR   65   RW register used as interrupt-enable mask (bits NEV-1:0)
//  IF_ADDR   68   W1C interrupt-flag register address
//  ST_BASE   69   first of ST_N read-only status words
//  ST_N      4    number of status words
//  NEV       8    number of event inputs (NEV <= DATA_W)
// PORTS
//  clk         in    1                  single clock; all bus signals sampled on posedge
//  rst         in    1                  synchronous reset, active-low
//  ssram_we    in    1                  write strobe (one write per cycle while high)
//  ssram_re    in    1                  read strobe
//  ssram_addr  in    ADDR_W             register address
//  ssram_data  inout DATA_W             shared data bus; Z unless read data valid
//  ssram_out   out   RW_DEPTH*DATA_W    flattened RW bank, reg k at [k*DATA_W +: DATA_W]
//  st_in       in    ST_N*DATA_W        live status words from core
//  ev_in       in    NEV                event pulses, one cycle each (e.g. vr edge)
//  wr_stb      out   1                  1-cycle pulse after any accepted write
//  wr_addr     out   ADDR_W             address of last accepted write
//  irq         out   1                  |(if_reg & ie_reg[NEV-1:0]), registered
// BEHAVIOUR
//  Reset (rst==0 at posedge): all RW regs, if_reg, wr_addr, read latch = 0; wr_stb=0; irq=0; bus drive enable=0 (ssram_data Z).
//  Write: posedge with we=1: addr<RW_DEPTH -> reg[addr]<=ssram_data; addr==IF_ADDR -> if_reg &= ~data[NEV-1:0];
//   status/unmapped addr -> ignored. wr_stb=1 and wr_addr=addr next cycle for every sampled write (mapped or not).
//  Back-to-back writes: one per cycle; address may repeat; last write wins.
//  Read: posedge with re=1 and we=0 latches rd_data for addr and sets drive enable; ssram_data valid exactly 1 cycle after re sampled,
//   updated every cycle while re held (address may change each cycle, pipelined 1 deep); drive enable clears on first edge with re=0.
//  Read map: 0..RW_DEPTH-1 reg; IF_ADDR zero-extended if_reg; ST_BASE..ST_BASE+ST_N-1 st_in word (sampled at read edge); else 0.
//  we and re both high: write performed, read ignored, drive enable forced 0 that cycle (no bus contention).
//  Events: ev_in[i]=1 at posedge sets if_reg[i]; same edge as W1C clearing bit i -> set wins (flag stays 1). Flags never self-clear.
//  irq registered: reflects if_reg/ie at previous edge -> 1-cycle latency from event; IE write masks/unmasks with same latency.
//  Address wider than map: only full ADDR_W compare used, no aliasing.
//  Reset mid-transfer: drive released and write discarded on that edge; first post-reset cycle is a normal idle cycle.
// TESTING
//  T1 reset: rst=0 2 cycles, we=re=0 -> ssram_data Z, irq=0, all ssram_out 0, wr_stb 0.
//  T2 burst write addr 0..67 (addr0=3, 64=16'b111, 65=1, else 0) -> ssram_out matches; 68 wr_stb pulses; readback 0..67 gives same, 1-cycle latency.
//  T3 ev_in[0] pulse, IE=1 -> if_reg reads 1, irq=1 next cycle; write IF_ADDR=1 -> irq 0; IE=0 with flag set -> irq 0.
//  T4 ev_in[0] same edge as W1C of bit0 -> flag remains 1; write 16'hFFFE to IF_ADDR leaves bit0 set.
//  T5 we=re=1 addr 5 data 16'hA5A5 -> reg5=A5A5, bus never driven by slave; read addr 200 -> 16'h0000; write addr 200 -> no reg change, wr_stb=1.
//  T6 rst low during held read of addr 64 -> ssram_data Z next cycle, ssram_out[64]=0; st_in word 2=16'h1234 read at ST_BASE+2 -> 16'h1234.

Source files
------------

// File: rtl/hwag_ssram_slave.sv
// hwag_ssram_slave: SSRAM-style register responder for the HWAG core.
// It holds the RW config bank, sticky W1C event flags and read-only status words, and raises a level irq.
module hwag_ssram_slave #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RW_DEPTH = 68,
  parameter int IE_ADDR  = 65,
  parameter int IF_ADDR  = 68,
  parameter int ST_BASE  = 69,
  parameter int ST_N     = 4,
  parameter int NEV      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ssram_we,
  input  logic                       ssram_re,
  input  logic [ADDR_W-1:0]          ssram_addr,
  inout  wire  [DATA_W-1:0]          ssram_data,
  output logic [RW_DEPTH*DATA_W-1:0] ssram_out,
  input  logic [ST_N*DATA_W-1:0]     st_in,
  input  logic [NEV-1:0]             ev_in,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       irq
);

  localparam int                IDX_W  = $clog2(RW_DEPTH);
  localparam logic [ADDR_W-1:0] RW_LIM = ADDR_W'(RW_DEPTH);
  localparam logic [ADDR_W-1:0] IF_A   = ADDR_W'(IF_ADDR);

  logic [DATA_W-1:0] rw_q [RW_DEPTH];
  logic [NEV-1:0]    if_q, if_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              drv_q;
  logic              wr_stb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              irq_q;

  logic [IDX_W-1:0]  rw_idx;
  logic              rw_hit;
  logic              if_hit;
  logic              rd_req;
  logic [NEV-1:0]    ie;

  assign rw_idx = ssram_addr[IDX_W-1:0];
  assign rw_hit = (ssram_addr < RW_LIM);
  assign if_hit = (ssram_addr == IF_A);
  assign rd_req = ssram_re & ~ssram_we;
  assign ie     = rw_q[IE_ADDR][NEV-1:0];

  // Full-width address decode; anything outside the map reads back as zero.
  always_comb begin
    rd_data_d = '0;
    if (rw_hit) begin
      rd_data_d = rw_q[rw_idx];
    end else if (if_hit) begin
      rd_data_d = DATA_W'(if_q);
    end else begin
      for (int k = 0; k < ST_N; k++) begin
        if (ssram_addr == ADDR_W'(ST_BASE + k)) begin
          rd_data_d = st_in[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // The event OR is applied after the W1C mask so that a set on the same edge wins.
  always_comb begin
    if_d = if_q;
    if (ssram_we && if_hit) begin
      if_d = if_q & ~ssram_data[NEV-1:0];
    end
    if_d = if_d | ev_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < RW_DEPTH; k++) begin
        rw_q[k] <= '0;
      end
      if_q      <= '0;
      rd_data_q <= '0;
      drv_q     <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (ssram_we && rw_hit) begin
        rw_q[rw_idx] <= ssram_data;
      end
      if (ssram_we) begin
        wr_addr_q <= ssram_addr;
      end
      wr_stb_q <= ssram_we;
      if_q     <= if_d;
      irq_q    <= |(if_q & ie);
      drv_q    <= rd_req;
      if (rd_req) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  // The bus is released as soon as a master asserts we, so it never fights an incoming write.
  assign ssram_data = (drv_q && !ssram_we) ? rd_data_q : {DATA_W{1'bz}};

  for (genvar k = 0; k < RW_DEPTH; k++) begin : g_out
    assign ssram_out[k*DATA_W +: DATA_W] = rw_q[k];
  end

  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_hwag_ssram_slave.sv
// tb_hwag_ssram_slave: directed and randomized checks of hwag_ssram_slave against a register-map model.
// A pullup on the data bus makes a released bus read as all ones.
module tb_hwag_ssram_slave;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int RW_DEPTH = 68;
  localparam int IE_ADDR  = 65;
  localparam int IF_ADDR  = 68;
  localparam int ST_BASE  = 69;
  localparam int ST_N     = 4;
  localparam int NEV      = 8;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       ssram_we = 1'b0;
  logic                       ssram_re = 1'b0;
  logic [ADDR_W-1:0]          ssram_addr = '0;
  wire  [DATA_W-1:0]          ssram_data;
  logic [RW_DEPTH*DATA_W-1:0] ssram_out;
  logic [ST_N*DATA_W-1:0]     st_in = '0;
  logic [NEV-1:0]             ev_in = '0;
  logic                       wr_stb;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       irq;

  logic              tb_oe = 1'b0;
  logic [DATA_W-1:0] tb_dout = '0;

  assign ssram_data = tb_oe ? tb_dout : {DATA_W{1'bz}};

  for (genvar i = 0; i < DATA_W; i++) begin : g_pu
    pullup (ssram_data[i]);
  end

  hwag_ssram_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RW_DEPTH(RW_DEPTH), .IE_ADDR(IE_ADDR),
    .IF_ADDR(IF_ADDR), .ST_BASE(ST_BASE), .ST_N(ST_N), .NEV(NEV)
  ) dut (
    .clk(clk), .rst(rst), .ssram_we(ssram_we), .ssram_re(ssram_re),
    .ssram_addr(ssram_addr), .ssram_data(ssram_data), .ssram_out(ssram_out),
    .st_in(st_in), .ev_in(ev_in), .wr_stb(wr_stb), .wr_addr(wr_addr), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_rw [RW_DEPTH];
  logic [NEV-1:0]    m_if;
  logic              exp_irq;
  logic              exp_stb;
  logic [ADDR_W-1:0] exp_wr_addr;
  logic [DATA_W-1:0] exp_bus;

  localparam logic [DATA_W-1:0] RELEASED = 16'hFFFF;

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    int ia;
    ia = int'(a);
    if (ia < RW_DEPTH) return m_rw[ia];
    if (ia == IF_ADDR) return DATA_W'(m_if);
    if (ia >= ST_BASE && ia < ST_BASE + ST_N) return st_in[(ia-ST_BASE)*DATA_W +: DATA_W];
    return '0;
  endfunction

  function automatic logic [RW_DEPTH*DATA_W-1:0] model_flat();
    logic [RW_DEPTH*DATA_W-1:0] v;
    for (int k = 0; k < RW_DEPTH; k++) v[k*DATA_W +: DATA_W] = m_rw[k];
    return v;
  endfunction

  // Drives one bus cycle, advances the model across the posedge and stops at the following negedge.
  task automatic step(input logic r_n, input logic we, input logic re,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [NEV-1:0] ev);
    logic [NEV-1:0] w1c;
    rst = r_n; ssram_we = we; ssram_re = re; ssram_addr = a; ev_in = ev;
    tb_oe = we; tb_dout = d;
    if (!r_n) begin
      for (int k = 0; k < RW_DEPTH; k++) m_rw[k] = '0;
      m_if = '0; exp_irq = 1'b0; exp_stb = 1'b0; exp_wr_addr = '0;
      exp_bus = we ? d : RELEASED;
    end else begin
      exp_irq = |(m_if & m_rw[IE_ADDR][NEV-1:0]);
      exp_stb = we;
      if (we) exp_wr_addr = a;
      exp_bus = we ? d : (re ? model_read(a) : RELEASED);
      w1c = (we && int'(a) == IF_ADDR) ? d[NEV-1:0] : '0;
      if (we && int'(a) < RW_DEPTH) m_rw[int'(a)] = d;
      m_if = (m_if & ~w1c) | ev;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (ssram_data !== RELEASED) begin errors++; $display("[TB] FAIL reset_bus got %h exp %h", ssram_data, RELEASED); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b exp 0", irq); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_stb got %b exp 0", wr_stb); end
    checks++; if (wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_wr_addr got %h exp 0", wr_addr); end
    checks++; if (ssram_out !== '0) begin errors++; $display("[TB] FAIL reset_ssram_out nonzero got %h", ssram_out[255:0]); end
  endtask

  task automatic test_burst();
    logic [DATA_W-1:0] v;
    int pulses;
    pulses = 0;
    for (int k = 0; k < RW_DEPTH; k++) begin
      v = (k == 0) ? 16'd3 : (k == 64) ? 16'b111 : (k == 65) ? 16'd1 : 16'd0;
      step(1'b1, 1'b1, 1'b0, ADDR_W'(k), v, '0);
      if (wr_stb === 1'b1) pulses++;
      checks++; if (wr_addr !== ADDR_W'(k)) begin errors++; $display("[TB] FAIL burst_wr_addr got %0d exp %0d", wr_addr, k); end
    end
    checks++; if (pulses != RW_DEPTH) begin errors++; $display("[TB] FAIL burst_pulses got %0d exp %0d", pulses, RW_DEPTH); end
    checks++; if (ssram_out !== model_flat()) begin errors++; $display("[TB] FAIL burst_out got %h exp %h", ssram_out[127:0], model_flat()[127:0]); end
    checks++; if (ssram_out[64*DATA_W +: DATA_W] !== 16'h0007) begin errors++; $display("[TB] FAIL burst_reg64 got %h exp 0007", ssram_out[64*DATA_W +: DATA_W]); end
    for (int k = 0; k < RW_DEPTH; k++) begin
      step(1'b1, 1'b0, 1'b1, ADDR_W'(k), '0, '0);
      checks++; if (ssram_data !== exp_bus) begin errors++; $display("[TB] FAIL burst_readback addr %0d got %h exp %h", k, ssram_data, exp_bus); end
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (ssram_data !== RELEASED) begin errors++; $display("[TB] FAIL burst_release got %h exp %h", ssram_data, RELEASED); end
  endtask

  task automatic test_irq();
    step(1'b1, 1'b0, 1'b0, '0, '0, 8'h01);
    checks++; if (irq !== exp_irq) begin errors++; $display("[TB] FAIL irq_event_edge got %b exp %b", irq, exp_irq); end
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_assert got %b exp 1", irq); end
    step(1'b1, 1'b0, 1'b1, ADDR_W'(IF_ADDR), '0, '0);
    checks++; if (ssram_data !== 16'h0001) begin errors++; $display("[TB] FAIL irq_flag_read got %h exp 0001", ssram_data); end
    step(1'b1, 1'b1, 1'b0, ADDR_W'(IF_ADDR), 16'h0001, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_after_w1c got %b exp 0", irq); end
    step(1'b1, 1'b0, 1'b0, '0, '0, 8'h01);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (irq !== exp_irq) begin errors++; $display("[TB] FAIL irq_reassert got %b exp %b", irq, exp_irq); end
    step(1'b1, 1'b1, 1'b0, ADDR_W'(IE_ADDR), 16'h0000, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_masked got %b exp 0", irq); end
  endtask

  task automatic test_w1c_race();
    step(1'b1, 1'b0, 1'b0, '0, '0, 8'h01);
    step(1'b1, 1'b1, 1'b0, ADDR_W'(IF_ADDR), 16'h0001, 8'h01);
    step(1'b1, 1'b0, 1'b1, ADDR_W'(IF_ADDR), '0, '0);
    checks++; if (ssram_data !== 16'h0001) begin errors++; $display("[TB] FAIL race_set_wins got %h exp 0001", ssram_data); end
    step(1'b1, 1'b1, 1'b0, ADDR_W'(IF_ADDR), 16'hFFFE, '0);
    step(1'b1, 1'b0, 1'b1, ADDR_W'(IF_ADDR), '0, '0);
    checks++; if (ssram_data !== exp_bus || ssram_data[0] !== 1'b1) begin errors++; $display("[TB] FAIL race_w1c_other_bits got %h exp %h", ssram_data, exp_bus); end
  endtask

  task automatic test_collision();
    step(1'b1, 1'b0, 1'b1, 8'd0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 8'd5, 16'hA5A5, '0);
    checks++; if (ssram_data !== 16'hA5A5) begin errors++; $display("[TB] FAIL coll_bus_during got %h exp a5a5", ssram_data); end
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (ssram_data !== RELEASED) begin errors++; $display("[TB] FAIL coll_no_drive got %h exp %h", ssram_data, RELEASED); end
    checks++; if (ssram_out[5*DATA_W +: DATA_W] !== 16'hA5A5) begin errors++; $display("[TB] FAIL coll_reg5 got %h exp a5a5", ssram_out[5*DATA_W +: DATA_W]); end
    step(1'b1, 1'b0, 1'b1, 8'd200, '0, '0);
    checks++; if (ssram_data !== 16'h0000) begin errors++; $display("[TB] FAIL unmapped_read got %h exp 0000", ssram_data); end
    step(1'b1, 1'b1, 1'b0, 8'd200, 16'hBEEF, '0);
    checks++; if (wr_stb !== 1'b1 || wr_addr !== 8'd200) begin errors++; $display("[TB] FAIL unmapped_wr_stb got %b/%0d exp 1/200", wr_stb, wr_addr); end
    checks++; if (ssram_out !== model_flat()) begin errors++; $display("[TB] FAIL unmapped_write_alias got %h exp %h", ssram_out[255:0], model_flat()[255:0]); end
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 1'b0, 1'b1, 8'd64, '0, '0);
    checks++; if (ssram_data !== 16'h0007) begin errors++; $display("[TB] FAIL mid_read_pre got %h exp 0007", ssram_data); end
    step(1'b0, 1'b0, 1'b1, 8'd64, '0, '0);
    checks++; if (ssram_data !== RELEASED) begin errors++; $display("[TB] FAIL mid_read_release got %h exp %h", ssram_data, RELEASED); end
    checks++; if (ssram_out[64*DATA_W +: DATA_W] !== 16'h0000) begin errors++; $display("[TB] FAIL mid_read_reg64 got %h exp 0000", ssram_out[64*DATA_W +: DATA_W]); end
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (ssram_data !== RELEASED || wr_stb !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got %h/%b exp %h/0", ssram_data, wr_stb, RELEASED); end
    st_in = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
    step(1'b1, 1'b0, 1'b1, ADDR_W'(ST_BASE + 2), '0, '0);
    checks++; if (ssram_data !== 16'h1234) begin errors++; $display("[TB] FAIL status_read got %h exp 1234", ssram_data); end
  endtask

  task automatic test_random();
    int op, r;
    logic we, re;
    logic [ADDR_W-1:0] a;
    logic [NEV-1:0] ev;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      we = (op <= 3) || (op == 9);
      re = (op >= 4 && op <= 7) || (op == 9);
      r  = $urandom_range(0, 15);
      a  = (r == 0) ? 8'd200 : (r == 1) ? ADDR_W'($urandom_range(73, 255)) : ADDR_W'($urandom_range(0, 72));
      ev = ($urandom_range(0, 3) == 0) ? NEV'($urandom) : '0;
      st_in = {$urandom, $urandom};
      step(1'b1, we, re, a, DATA_W'($urandom), ev);
      checks++; if (ssram_data !== exp_bus) begin errors++; $display("[TB] FAIL rand_bus n=%0d got %h exp %h", n, ssram_data, exp_bus); end
      checks++; if (irq !== exp_irq) begin errors++; $display("[TB] FAIL rand_irq n=%0d got %b exp %b", n, irq, exp_irq); end
      checks++; if (wr_stb !== exp_stb) begin errors++; $display("[TB] FAIL rand_wr_stb n=%0d got %b exp %b", n, wr_stb, exp_stb); end
      checks++; if (wr_addr !== exp_wr_addr) begin errors++; $display("[TB] FAIL rand_wr_addr n=%0d got %h exp %h", n, wr_addr, exp_wr_addr); end
      if (n % 50 == 49) begin
        checks++; if (ssram_out !== model_flat()) begin errors++; $display("[TB] FAIL rand_out n=%0d got %h exp %h", n, ssram_out[255:0], model_flat()[255:0]); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_burst();
    test_irq();
    test_w1c_race();
    test_collision();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
